drum_trigger_pio: RTL and testbench



---
 rtl/drum_trigger_pio.sv | 138 +++++++++++++
 tb/tb_drum_trigger_pio.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_trigger_pio.sv
`default_nettype none
// ============================================================================
// Module   : drum_trigger_pio
// Purpose  : Avalon-MM input PIO for drum-pad triggers: per-channel sync,
//            programmable debounce, rise/fall edge capture with W1C and IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module drum_trigger_pio #(
  parameter int WIDTH          = 8,
  parameter int CNT_W          = 16,
  parameter int DEBOUNCE_RESET = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] c_ADDR_DATA  = 3'd0;
  localparam logic [2:0] c_ADDR_RISE  = 3'd1;
  localparam logic [2:0] c_ADDR_MASK  = 3'd2;
  localparam logic [2:0] c_ADDR_EDGE  = 3'd3;
  localparam logic [2:0] c_ADDR_FALL  = 3'd4;
  localparam logic [2:0] c_ADDR_LIMIT = 3'd5;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_deb;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [CNT_W-1:0] r_limit;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_deb_next;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_wdata        = writedata[WIDTH-1:0];
  assign w_unused_wdata = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  // Counter restarts whenever sync matches deb, so only an uninterrupted
  // run of L+1 differing samples can move the debounced level.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_hit;

    assign w_diff         = r_sync2[gi] ^ r_deb[gi];
    assign w_hit          = w_diff & (r_cnt >= r_limit);
    assign w_deb_next[gi] = w_hit ? r_sync2[gi] : r_deb[gi];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (!w_diff || w_hit) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign w_set = (~r_deb & w_deb_next & r_rise_en) | (r_deb & ~w_deb_next & r_fall_en);
  assign w_clr = (w_wr && address == c_ADDR_EDGE) ? w_wdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_deb      <= '0;
      r_edge_cap <= '0;
    end else begin
      r_deb      <= w_deb_next;
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_set;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_irq_mask <= '0;
      r_limit    <= CNT_W'(DEBOUNCE_RESET);
    end else if (w_wr) begin
      case (address)
        c_ADDR_RISE:  r_rise_en  <= w_wdata;
        c_ADDR_MASK:  r_irq_mask <= w_wdata;
        c_ADDR_FALL:  r_fall_en  <= w_wdata;
        c_ADDR_LIMIT: r_limit    <= writedata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      c_ADDR_DATA:  w_rd_mux = 32'(r_deb);
      c_ADDR_RISE:  w_rd_mux = 32'(r_rise_en);
      c_ADDR_MASK:  w_rd_mux = 32'(r_irq_mask);
      c_ADDR_EDGE:  w_rd_mux = 32'(r_edge_cap);
      c_ADDR_FALL:  w_rd_mux = 32'(r_fall_en);
      c_ADDR_LIMIT: w_rd_mux = 32'(r_limit);
      default:      w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= w_rd_mux;
    end
  end

  assign irq = |(r_edge_cap & r_irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_drum_trigger_pio.sv
`default_nettype none
// ============================================================================
// Module   : tb_drum_trigger_pio
// Purpose  : Scoreboard bench for drum_trigger_pio with a window-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drum_trigger_pio;

  localparam int WIDTH          = 8;
  localparam int CNT_W          = 16;
  localparam int DEBOUNCE_RESET = 50000;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  drum_trigger_pio #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .DEBOUNCE_RESET(DEBOUNCE_RESET)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        irq;
  } exp_t;
  exp_t sb[$];

  // Model: deb flips when the last L+1 synchronised samples all disagree with it.
  bit [WIDTH-1:0] m_deb, m_rise, m_fall, m_mask, m_cap;
  int             m_lim;
  bit [WIDTH-1:0] hist[$];

  function automatic void model_reset();
    m_deb = '0; m_rise = '0; m_fall = '0; m_mask = '0; m_cap = '0;
    m_lim = DEBOUNCE_RESET;
    hist.delete();
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_deb);
      3'd1: return 32'(m_rise);
      3'd2: return 32'(m_mask);
      3'd3: return 32'(m_cap);
      3'd4: return 32'(m_fall);
      3'd5: return 32'(m_lim);
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a negedge with inputs driven; models one posedge.
  task automatic cycle();
    exp_t           e;
    bit [WIDTH-1:0] nd, set, clr, w;
    bit             ok, wr;
    int             idx;
    e.data = model_read(address);
    hist.push_back(in_port);
    if (hist.size() > 64) void'(hist.pop_front());
    nd = m_deb;
    if (hist.size() >= m_lim + 3) begin
      for (int c = 0; c < WIDTH; c++) begin
        ok = 1'b1;
        for (int k = 0; k <= m_lim; k++) begin
          idx = hist.size() - 3 - k;
          w = hist[idx];
          if (w[c] == m_deb[c]) ok = 1'b0;
        end
        if (ok) nd[c] = ~m_deb[c];
      end
    end
    set = (~m_deb & nd & m_rise) | (m_deb & ~nd & m_fall);
    wr  = chipselect && !write_n;
    clr = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
    m_cap = (m_cap & ~clr) | set;
    m_deb = nd;
    if (wr) begin
      case (address)
        3'd1: m_rise = writedata[WIDTH-1:0];
        3'd2: m_mask = writedata[WIDTH-1:0];
        3'd4: m_fall = writedata[WIDTH-1:0];
        3'd5: m_lim  = int'(writedata[CNT_W-1:0]);
        default: ;
      endcase
    end
    e.irq = |(m_cap & m_mask);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cycle();
    write_n = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset && sb.size() > 0) begin
      e = sb.pop_front();
      check("readdata", readdata, e.data);
      check("irq", {31'd0, irq}, {31'd0, e.irq});
    end
  end

  int a;

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_readdata", readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    chipselect = 1'b1;

    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      cycle();
      if (i == 5) check("reset_limit", readdata, 32'h0000C350);
    end

    // Rising capture on channel 0 with L=3
    wr(3'd5, 32'd3); wr(3'd1, 32'h01); wr(3'd2, 32'h01);
    address = 3'd3;
    in_port[0] = 1'b1;
    repeat (5) cycle();
    check("irq_before_edge6", {31'd0, irq}, 32'd0);
    cycle();
    check("irq_at_edge6", {31'd0, irq}, 32'd1);
    address = 3'd0;
    repeat (2) cycle();
    check("deb0_set", readdata, 32'h01);

    // 3-cycle glitch on channel 1 must be rejected
    in_port[1] = 1'b1;
    repeat (3) cycle();
    in_port[1] = 1'b0;
    repeat (10) cycle();
    check("glitch_data", readdata, 32'h01);
    address = 3'd3;
    repeat (2) cycle();
    check("glitch_capture", readdata, 32'h01);

    // Falling capture on channel 7, W1C behaviour
    wr(3'd3, 32'h01); wr(3'd4, 32'h80); wr(3'd2, 32'h80);
    in_port[7] = 1'b1;
    repeat (8) cycle();
    in_port[7] = 1'b0;
    repeat (8) cycle();
    check("fall_irq", {31'd0, irq}, 32'd1);
    wr(3'd3, 32'h00);
    check("w1c_zero_irq", {31'd0, irq}, 32'd1);
    wr(3'd3, 32'h80);
    check("w1c_irq", {31'd0, irq}, 32'd0);
    address = 3'd3;
    repeat (2) cycle();
    check("w1c_capture", readdata, 32'h00);

    // W1C of bit 0 colliding with a fresh rising edge
    wr(3'd2, 32'h81);
    in_port[0] = 1'b0; repeat (8) cycle();
    in_port[0] = 1'b1; repeat (8) cycle();
    in_port[0] = 1'b0; repeat (8) cycle();
    check("pre_collide_irq", {31'd0, irq}, 32'd1);
    in_port[0] = 1'b1;
    repeat (5) cycle();
    wr(3'd3, 32'h01);
    check("collide_irq", {31'd0, irq}, 32'd1);
    address = 3'd3;
    repeat (2) cycle();
    check("collide_capture", readdata & 32'h01, 32'h01);

    // Reset in the middle of a debounce count on channel 2
    in_port[2] = 1'b1;
    address = 3'd0;
    repeat (4) cycle();
    #2 reset = 1'b1;
    sb.delete();
    model_reset();
    #1;
    check("async_reset_irq", {31'd0, irq}, 32'd0);
    check("async_reset_readdata", readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wr(3'd5, 32'd3);
    address = 3'd0;
    repeat (5) cycle();
    check("post_reset_deb2_low", readdata & 32'h04, 32'h00);
    cycle();
    check("post_reset_deb2_high", readdata & 32'h04, 32'h04);

    // Randomised phases
    for (int ph = 0; ph < 4; ph++) begin
      write_n = 1'b1; chipselect = 1'b1; address = 3'd0;
      repeat (20) cycle();
      wr(3'd5, 32'($urandom_range(1, 6)));
      wr(3'd1, $urandom); wr(3'd4, $urandom); wr(3'd2, $urandom);
      for (int n = 0; n < 500; n++) begin
        for (int c = 0; c < WIDTH; c++)
          if ($urandom_range(0, 7) == 0) in_port[c] = ~in_port[c];
        address = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 9) == 0) begin
          a = $urandom_range(0, 7);
          if (a == 5) a = 3;
          address    = 3'(a);
          writedata  = $urandom;
          chipselect = 1'($urandom_range(0, 1));
          write_n    = 1'b0;
          cycle();
          write_n    = 1'b1;
          chipselect = 1'b1;
        end else begin
          cycle();
        end
      end
    end

    @(negedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
